inst_queue: RTL
===============

Name: inst_queue

Overview:
- Decoupling instruction FIFO between the Fetch2 stage and Decode.
- Captures every valid Fetch2 output beat (pc, inst, btb_pre, is_pred plus exception info) and replays it to Decode in program order.
- Absorbs Decode back-pressure so the I-cache pipeline keeps streaming.
- Drops all contents on pipeline flush (branch redirect, exception, BP-error flush).

Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; discards all entries and any same-cycle push
- pass_in  in  fetch2_decode_pass_t  Fetch2 beat {valid, pc[31:0], inst[31:0], btb_pre[31:0], is_pred}
- excp_pass_in  in  excp_pass_t  exception info accompanying pass_in
- rdy_in  out  1  queue can accept a beat this cycle (to Fetch2 next_rdy_in)
- next_rdy_in  in  1  Decode accepts the head beat this cycle
- pass_out  out  fetch2_decode_pass_t  head beat to Decode; valid qualifies it
- excp_pass_out  out  excp_pass_t  exception info of the head beat
- occupancy  out  PTR_W+1  current entry count, for perf counters and debug

Behaviour:
- Storage: DEPTH-entry array of {pass fields minus valid, excp}.
- Pointers: wr_ptr and rd_ptr, each PTR_W+1 bits, with a wrap bit. The low PTR_W bits index the array.
- Status: empty = (wr_ptr == rd_ptr); full = low bits equal and wrap bits differ. occupancy = wr_ptr - rd_ptr, modulo 2^(PTR_W+1).
- rdy_in = ~full. It is a function of registers only and does not depend on next_rdy_in or flush.
- push = pass_in.valid & rdy_in & ~flush. On push, the array is written at wr_ptr and wr_ptr increments.
- pass_out.valid = ~empty & ~flush.
- First-word fall-through:
  - pass_out fields and excp_pass_out come combinationally from array[rd_ptr].
  - When empty, the fields are don't-care, but valid is 0.
- pop = pass_out.valid & next_rdy_in. On pop, rd_ptr increments.
- Latency: a beat pushed in cycle N is visible at pass_out in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous push and pop (not full, not empty): both occur and occupancy is unchanged.
- Full queue with a pop in the same cycle: no push, because rdy_in = 0 when full. Fetch2 re-offers the beat next cycle.
- Empty queue with a push: no pop that cycle; the entry appears next cycle.
- Flush:
  - On the next edge, wr_ptr <= 0, rd_ptr <= 0, and any same-cycle push and pop are suppressed.
  - In the cycle after flush, occupancy = 0, rdy_in = 1 and pass_out.valid = 0.
  - Flush has priority over push and pop.
- Wrap-around: pointers roll over naturally at 2^(PTR_W+1), and ordering is preserved across the roll.
- Reset (asynchronous, any time including mid-stream):
  - wr_ptr = 0, rd_ptr = 0, so pass_out.valid = 0, rdy_in = 1 and occupancy = 0 immediately.
  - Array contents are not reset.
- Exception beats are queued like any other beat. The queue never inspects excp_pass_in.
- Invariants (bench assertions):
  - occupancy <= DEPTH.
  - No push while full.
  - No pop while empty.
  - Beats exit in the order they entered, with fields bit-exact.

Test Plan:
- Fill/drain: DEPTH=8, next_rdy_in = 0, push 10 beats with pc 0x1c000000 + 4k.
  - Required: rdy_in falls after 8 accepted beats and occupancy = 8.
  - Then raise next_rdy_in: pc 0x1c000000..0x1c00001c appear one per cycle in order, and rdy_in = 1 one cycle after the first pop.
- Streaming: push every cycle with next_rdy_in = 1 for 40 cycles.
  - Required: occupancy settles at 1 and throughput is 1 beat/cycle.
  - Each beat appears exactly 1 cycle after its push; pointers wrap at least twice with no loss or reorder.
- Flush mid-stream: occupancy = 5, assert flush together with pass_in.valid = 1 (pc 0x1c000100).
  - Required: pass_out.valid = 0 in the flush cycle, occupancy = 0 next cycle, and pc 0x1c000100 is never emitted.
  - A push in the following cycle emerges next.
- Full plus pop: occupancy = 8, next_rdy_in = 1, pass_in.valid = 1.
  - Required: the offered beat is not accepted that cycle, occupancy = 7 next cycle, and the beat is accepted on re-offer.
- Exception and prediction fields: push a beat with is_pred = 1, btb_pre = 0x1c000040 and a nonzero excp_pass_in.
  - Required: all fields are emitted bit-exact.
- Async reset with occupancy = 6: assert rst_n = 0 between clock edges.
  - Required: pass_out.valid = 0 and occupancy = 0 without waiting for a clock edge, and rdy_in = 1.
  - After release, the first pushed beat is the first one emitted.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: first-word-fall-through instruction FIFO between Fetch2 and Decode.
// Holds Fetch2 beats plus their exception info, replays them in order, and empties on flush.
package inst_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] btb_pre;
        logic        is_pred;
    } fetch2_decode_pass_t;

    typedef struct packed {
        logic       excp;
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } excp_pass_t;
endpackage

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  fetch2_decode_pass_t pass_in,
    input  excp_pass_t          excp_pass_in,
    output logic                rdy_in,
    input  logic                next_rdy_in,
    output fetch2_decode_pass_t pass_out,
    output excp_pass_t          excp_pass_out,
    output logic [PTR_W:0]      occupancy
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] btb_pre;
        logic        is_pred;
        excp_pass_t  excp;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         head;
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           empty, full, push, pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty            = wr_ptr == rd_ptr;
        full             = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
        occupancy        = wr_ptr - rd_ptr;
        rdy_in           = ~full;
        push             = pass_in.valid & ~full & ~flush;
        head             = mem[rd_ptr[PTR_W-1:0]];
        pass_out.valid   = ~empty & ~flush;
        pass_out.pc      = head.pc;
        pass_out.inst    = head.inst;
        pass_out.btb_pre = head.btb_pre;
        pass_out.is_pred = head.is_pred;
        excp_pass_out    = head.excp;
        pop              = ~empty & ~flush & next_rdy_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= '{pass_in.pc, pass_in.inst, pass_in.btb_pre, pass_in.is_pred, excp_pass_in};
    end
endmodule
